// File: rtl/nes_controller_poll_scheduler.sv
// Poll scheduler for nes_controller_interface: launches fetches on a period
// or on request, captures the per-controller bytes and publishes a registered
// snapshot with pressed/released edge masks. Hung fetches are aborted.
module nes_controller_poll_scheduler #(
    parameter int NUM_CONTROLLERS = 4,
    parameter int POLL_PERIOD     = 16666,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_i,
    input  logic                         req_i,
    output logic                         ack_o,
    output logic                         start_fetch_o,
    input  logic                         valid_i,
    input  logic [8*NUM_CONTROLLERS-1:0] data_LIST_i,
    output logic [8*NUM_CONTROLLERS-1:0] buttons_LIST_o,
    output logic [8*NUM_CONTROLLERS-1:0] pressed_LIST_o,
    output logic [8*NUM_CONTROLLERS-1:0] released_LIST_o,
    output logic                         sample_o,
    output logic                         timeout_o,
    output logic                         busy_o
);

    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PER_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE,
        PUBLISH
    } state_t;

    state_t        state;
    logic [PW-1:0] per_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          auto_pending;
    logic          req_pending;
    logic          launch;
    logic          capture;
    logic          publish;

    // Controller 1 sits in the top byte, which is lane NUM_CONTROLLERS-1.
    logic [NUM_CONTROLLERS-1:0][7:0] data_v;
    logic [NUM_CONTROLLERS-1:0][7:0] buttons_v;
    logic [NUM_CONTROLLERS-1:0][7:0] pressed_v;
    logic [NUM_CONTROLLERS-1:0][7:0] released_v;

    assign data_v          = data_LIST_i;
    assign buttons_LIST_o  = buttons_v;
    assign pressed_LIST_o  = pressed_v;
    assign released_LIST_o = released_v;

    assign launch  = (state == IDLE) && (auto_pending || req_pending || req_i);
    assign capture = (state == WAIT_DONE) && valid_i;
    assign publish = (state == CAPTURE);

    // Free-running poll period; an expiry that lands on a launch is served by it.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt      <= '0;
            auto_pending <= 1'b0;
        end else begin
            if (enable_i) begin
                per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
            end
            if (launch) begin
                auto_pending <= 1'b0;
            end else if (enable_i && per_cnt == PER_LAST) begin
                auto_pending <= 1'b1;
            end
        end
    end

    // Fetch sequencer with registered handshake, pulse and busy outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            req_pending   <= 1'b0;
            start_fetch_o <= 1'b0;
            sample_o      <= 1'b0;
            ack_o         <= 1'b0;
            timeout_o     <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            sample_o  <= 1'b0;
            ack_o     <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state         <= ISSUE;
                        start_fetch_o <= 1'b1;
                        busy_o        <= 1'b1;
                        req_pending   <= req_pending | req_i;
                    end
                end
                ISSUE: begin
                    state   <= WAIT_BUSY;
                    tmo_cnt <= '0;
                end
                WAIT_BUSY: begin
                    if (!valid_i) begin
                        state         <= WAIT_DONE;
                        start_fetch_o <= 1'b0;
                        tmo_cnt       <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state         <= IDLE;
                        start_fetch_o <= 1'b0;
                        busy_o        <= 1'b0;
                        timeout_o     <= 1'b1;
                        ack_o         <= req_pending;
                        req_pending   <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (valid_i) begin
                        state <= CAPTURE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        timeout_o   <= 1'b1;
                        ack_o       <= req_pending;
                        req_pending <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    // Snapshot lands on this edge, so sample_o lines up with it.
                    state       <= PUBLISH;
                    sample_o    <= 1'b1;
                    ack_o       <= req_pending;
                    req_pending <= 1'b0;
                end
                PUBLISH: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    start_fetch_o <= 1'b0;
                    busy_o        <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_lane
        logic [7:0] captured;
        logic [7:0] btn_q;
        logic [7:0] prs_q;
        logic [7:0] rel_q;

        assign buttons_v[g]  = btn_q;
        assign pressed_v[g]  = prs_q;
        assign released_v[g] = rel_q;

        // Per-controller capture, then snapshot and edges against the previous one.
        always_ff @(posedge clk) begin
            if (rst) begin
                captured <= '0;
                btn_q    <= '0;
                prs_q    <= '0;
                rel_q    <= '0;
            end else begin
                if (capture) begin
                    captured <= data_v[g];
                end
                if (publish) begin
                    btn_q <= captured;
                    prs_q <= captured & ~btn_q;
                    rel_q <= ~captured & btn_q;
                end
            end
        end
    end

endmodule
